// File: rtl/cyt_rdma_deadlock_report_ctrl.sv
// Deadlock report controller: confirms persistent monitor block flags and
// serialises confirmed deadlocks round-robin onto one valid/ready report channel.
module cyt_rdma_deadlock_report_ctrl #(
  parameter int NUM_MON = 4,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               cfg_enable,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               cfg_clear,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [CNT_W-1:0]   rpt_cycles,
  output logic [NUM_MON-1:0] sticky_mask,
  output logic               any_deadlock,
  output logic [1:0]         dbg_state
);

  // Report channel handshake: rpt_valid rises with rpt_idx/rpt_cycles already
  // stable, all three hold until the edge where rpt_valid & rpt_ready, and
  // rpt_valid never drops without that handshake.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   NUM_MON_W = (IDX_W+1)'(NUM_MON);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MON - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt [NUM_MON];
  logic [NUM_MON-1:0] pending;
  logic [NUM_MON-1:0] fired;
  logic [NUM_MON-1:0] confirm;
  logic [NUM_MON-1:0] hs_clr;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win;
  logic               win_found;
  logic [IDX_W:0]     cand;
  logic [CNT_W-1:0]   eff_thresh;
  logic               handshake;

  assign eff_thresh = (cfg_thresh == '0) ? CNT_W'(1) : cfg_thresh;
  assign handshake  = rpt_valid & rpt_ready;
  assign hs_clr     = handshake ? (NUM_MON'(1) << rpt_idx) : '0;
  assign dbg_state  = state;

  // fired marks an episode that has already confirmed; it re-arms at count 0.
  always_comb begin
    confirm = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      confirm[i] = cfg_enable && !fired[i] && (cnt[i] >= eff_thresh);
    end
  end

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_MON; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= NUM_MON_W) cand = cand - NUM_MON_W;
      if (!win_found && pending[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win       = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_MON; i++) cnt[i] <= '0;
      fired        <= '0;
      pending      <= '0;
      sticky_mask  <= '0;
      any_deadlock <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        if (cfg_clear || !cfg_enable || !mon_block[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != '1) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (cnt[i] == '0) begin
          fired[i] <= 1'b0;
        end else if (confirm[i] && !cfg_clear) begin
          fired[i] <= 1'b1;
        end
      end
      // A fresh confirm on the handshake edge survives the winner's clear.
      pending      <= cfg_clear ? '0 : ((pending & ~hs_clr) | confirm);
      sticky_mask  <= cfg_clear ? '0 : (sticky_mask | confirm);
      any_deadlock <= |sticky_mask;
    end
  end

  // The snapshot is taken on the edge into ARB; ARB then raises rpt_valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      rpt_valid  <= 1'b0;
      rpt_idx    <= '0;
      rpt_cycles <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            rpt_idx    <= win;
            rpt_cycles <= cnt[win];
            state      <= ST_ARB;
          end
        end
        ST_ARB: begin
          rpt_valid <= 1'b1;
          state     <= ST_REPORT;
        end
        ST_REPORT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            ptr       <= (rpt_idx == LAST_IDX) ? '0 : rpt_idx + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rpt_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cyt_rdma_deadlock_report_ctrl.sv
// Bench for cyt_rdma_deadlock_report_ctrl: directed scenarios plus random
// stimulus, all checked cycle by cycle against a behavioural model.
module tb_cyt_rdma_deadlock_report_ctrl;
  localparam int N     = 4;
  localparam int CNT_W = 16;
  localparam int IDX_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset_n;
  logic [N-1:0]     mon_block;
  logic             cfg_enable;
  logic [CNT_W-1:0] cfg_thresh;
  logic             cfg_clear;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [IDX_W-1:0] rpt_idx;
  logic [CNT_W-1:0] rpt_cycles;
  logic [N-1:0]     sticky_mask;
  logic             any_deadlock;
  logic [1:0]       dbg_state;

  cyt_rdma_deadlock_report_ctrl #(.NUM_MON(N), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset_n(reset_n), .mon_block(mon_block),
    .cfg_enable(cfg_enable), .cfg_thresh(cfg_thresh), .cfg_clear(cfg_clear),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx),
    .rpt_cycles(rpt_cycles), .sticky_mask(sticky_mask),
    .any_deadlock(any_deadlock), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // behavioural model: run lengths, episode flags, pending set, report slot
  int         m_cnt [N];
  bit [N-1:0] m_fired;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_sticky;
  bit         m_any;
  bit         m_valid;
  bit         m_gap;
  int         m_idx;
  int         m_cycles;
  int         m_ptr;

  logic [IDX_W-1:0] exp_q[$];
  int               hs_log[$];
  int               hs_count = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_fired = '0; m_pend = '0; m_sticky = '0; m_any = 0;
    m_valid = 0; m_gap = 0; m_idx = 0; m_cycles = 0; m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int         eff;
    int         w;
    bit [N-1:0] conf;
    bit [N-1:0] hs_mask;
    bit [N-1:0] old_pend;
    eff      = (cfg_thresh == 0) ? 1 : int'(cfg_thresh);
    conf     = '0;
    hs_mask  = '0;
    old_pend = m_pend;
    for (int i = 0; i < N; i++) conf[i] = cfg_enable && !m_fired[i] && (m_cnt[i] >= eff);
    if (m_valid) begin
      if (rpt_ready) begin
        hs_mask[m_idx] = 1'b1;
        m_valid = 0;
        m_ptr   = (m_idx + 1) % N;
      end
    end else if (m_gap) begin
      m_valid = 1;
      m_gap   = 0;
    end else if (old_pend != 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && old_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      m_idx    = w;
      m_cycles = m_cnt[w];
      m_gap    = 1;
      exp_q.push_back(IDX_W'(w));
    end
    m_any    = |m_sticky;
    m_pend   = cfg_clear ? '0 : ((old_pend & ~hs_mask) | conf);
    m_sticky = cfg_clear ? '0 : (m_sticky | conf);
    for (int i = 0; i < N; i++) begin
      if (m_cnt[i] == 0) m_fired[i] = 0;
      else if (conf[i] && !cfg_clear) m_fired[i] = 1;
      if (cfg_clear || !cfg_enable || !mon_block[i]) m_cnt[i] = 0;
      else m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
    end
  endtask

  // scoreboard side: every accepted report must match the next expected winner
  task automatic observe_handshake();
    if (rpt_valid && rpt_ready) begin
      hs_count++;
      hs_log.push_back(int'(rpt_idx));
      check("hs_has_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("hs_idx", 32'(rpt_idx), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic compare();
    check("rpt_valid",    32'(rpt_valid),    32'(m_valid));
    check("rpt_idx",      32'(rpt_idx),      32'(m_idx));
    check("rpt_cycles",   32'(rpt_cycles),   32'(m_cycles));
    check("sticky_mask",  32'(sticky_mask),  32'(m_sticky));
    check("any_deadlock", 32'(any_deadlock), 32'(m_any));
  endtask

  task automatic step();
    observe_handshake();
    model_edge();
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic drive(input logic [N-1:0] mon, input logic en, input int thr,
                       input logic clr, input logic rdy);
    mon_block  = mon;
    cfg_enable = en;
    cfg_thresh = CNT_W'(thr);
    cfg_clear  = clr;
    rpt_ready  = rdy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #3;
    check("rst_valid",  32'(rpt_valid),    0);
    check("rst_sticky", 32'(sticky_mask),  0);
    check("rst_any",    32'(any_deadlock), 0);
    check("rst_cycles", 32'(rpt_cycles),   0);
    check("rst_idx",    32'(rpt_idx),      0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!rpt_valid && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(rpt_valid), 1);
  endtask

  initial begin
    int base;
    drive('0, 0, 1, 0, 0);
    reset_n = 1'b0;
    model_reset();
    #2;
    do_reset();

    // persistence latency with thresh 8, then a 20-cycle stall
    drive(4'b0001, 1, 8, 0, 0);
    for (int n = 1; n <= 11; n++) begin
      step();
      if (n == 8)  check("t1_sticky_e8", 32'(sticky_mask), 0);
      if (n == 9)  begin check("t1_sticky_e9", 32'(sticky_mask), 1); check("t1_any_e9", 32'(any_deadlock), 0); end
      if (n == 10) begin check("t1_any_e10", 32'(any_deadlock), 1); check("t1_valid_e10", 32'(rpt_valid), 0); end
      if (n == 11) begin
        check("t1_valid_e11",  32'(rpt_valid), 1);
        check("t1_idx_e11",    32'(rpt_idx), 0);
        check("t1_cycles_e11", 32'(rpt_cycles), 9);
      end
    end
    run(20);
    check("t4_stall_cycles", 32'(rpt_cycles), 9);
    check("t4_stall_valid",  32'(rpt_valid), 1);
    rpt_ready = 1'b1;
    step();
    check("t4_accept_drop", 32'(rpt_valid), 0);
    drive('0, 1, 8, 0, 0);
    run(4);

    // short blip must not confirm; a long one gives exactly one report
    drive(4'b0100, 1, 8, 0, 0);
    run(5);
    drive('0, 1, 8, 0, 0);
    run(3);
    check("t2_blip_sticky", 32'(sticky_mask), 32'(4'b0001));
    base = hs_count;
    drive(4'b0100, 1, 8, 0, 1);
    run(14);
    drive('0, 1, 8, 0, 1);
    run(4);
    check("t2_one_report", 32'(hs_count - base), 1);
    check("t2_report_idx", 32'(hs_log[hs_log.size()-1]), 2);

    // round-robin order from pointer 0, then re-confirmed monitor 0
    do_reset();
    hs_log.delete();
    drive(4'b1011, 1, 4, 0, 1);
    run(16);
    drive(4'b1010, 1, 4, 0, 1);
    run(2);
    drive(4'b1011, 1, 4, 0, 1);
    run(10);
    drive('0, 1, 4, 0, 1);
    run(6);
    check("t3_num_reports", 32'(hs_log.size()), 4);
    if (hs_log.size() == 4) begin
      check("t3_order0", 32'(hs_log[0]), 0);
      check("t3_order1", 32'(hs_log[1]), 1);
      check("t3_order2", 32'(hs_log[2]), 3);
      check("t3_order3", 32'(hs_log[3]), 0);
    end

    // cfg_clear during REPORT keeps the report alive
    drive(4'b0100, 1, 3, 0, 0);
    wait_valid("t5_reach_report", 20);
    drive('0, 1, 3, 1, 0);
    step();
    check("t5_clear_sticky", 32'(sticky_mask), 0);
    check("t5_clear_valid",  32'(rpt_valid), 1);
    drive('0, 1, 3, 0, 0);
    run(3);
    check("t5_held_valid", 32'(rpt_valid), 1);
    base = hs_count;
    rpt_ready = 1'b1;
    run(20);
    check("t5_no_more", 32'(hs_count - base), 1);
    check("t5_idle_valid", 32'(rpt_valid), 0);

    // asynchronous reset in the middle of a REPORT
    drive(4'b0001, 1, 2, 0, 0);
    wait_valid("t6_reach_report", 20);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_valid",  32'(rpt_valid), 0);
    check("t6_async_sticky", 32'(sticky_mask), 0);
    drive(4'b1010, 1, 2, 0, 1);
    @(negedge clock);
    reset_n = 1'b1;
    base = hs_log.size();
    run(12);
    check("t6_first_after_rst", 32'(hs_log.size() > base ? hs_log[base] : -1), 1);

    // lowering the threshold mid-count confirms on the next edge
    drive('0, 1, 10, 1, 1);
    step();
    drive('0, 1, 10, 0, 1);
    run(8);
    drive(4'b0010, 1, 10, 0, 1);
    run(5);
    check("t7_before_lower", 32'(sticky_mask), 0);
    cfg_thresh = CNT_W'(3);
    step();
    check("t7_after_lower", 32'(sticky_mask), 32'(4'b0010));
    drive('0, 1, 3, 0, 1);
    run(8);

    // random traffic
    drive('0, 1, 3, 0, 0);
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) mon_block[i] = ~mon_block[i];
      end
      if ($urandom_range(0, 49) == 0) cfg_thresh = CNT_W'($urandom_range(0, 6));
      cfg_enable = ($urandom_range(0, 19) != 0);
      cfg_clear  = ($urandom_range(0, 99) == 0);
      rpt_ready  = ($urandom_range(0, 1) == 1);
      step();
    end
    drive('0, 1, 3, 0, 1);
    run(30);
    check("final_drained", 32'(rpt_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
